mux_scan_reg: RTL and testbench

- Parametrised, registered N-to-1 multiplexer of W-bit channels (N = 2**SW), successor to the fixed 16:1 single-bit mux.
- Two modes: manual select (S drives the channel) and auto-scan (an internal pointer steps through enabled channels with a programmable dwell).
- Provides a registered output, a channel tag, a valid strobe and a wrap pulse.
- Sits between a bank of sampled sources and a single downstream consumer, such as a serialiser or monitor.

---
 rtl/mux_scan_reg.sv | 139 +++++++++++++
 tb/tb_mux_scan_reg.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mux_scan_reg.sv
// Registered N:1 channel mux with manual select and masked auto-scan.
// Scan pointer dwells DWELL enabled cycles per channel, then hops to the next masked one.
module mux_scan_reg #(
    parameter int SW    = 4,
    parameter int W     = 1,
    parameter int DWELL = 1
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [(2**SW)*W-1:0]    I,
    input  logic [SW-1:0]           S,
    input  logic                    MODE,
    input  logic                    EN,
    input  logic [(2**SW)-1:0]      CH_MASK,
    output logic [W-1:0]            Y,
    output logic [SW-1:0]           Y_CH,
    output logic                    Y_VALID,
    output logic                    WRAP
);

    localparam int N = 2**SW;
    localparam logic [7:0] DLAST = 8'(DWELL - 1);

    typedef enum logic {MANUAL, SCAN} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  y_q, y_d;
    logic [SW-1:0] ch_q, ch_d;
    logic          vld_q, vld_d;
    logic          wrap_q, wrap_d;
    logic          pend_q, pend_d;
    logic [SW-1:0] p_q, p_d;
    logic [7:0]    d_q, d_d;

    logic [W-1:0]  ch_data [N];
    logic [SW-1:0] nxt;
    logic [SW-1:0] idx;
    logic          found;
    logic          nxt_wraps;

    for (genvar k = 0; k < N; k++) begin : g_split
        assign ch_data[k] = I[k*W +: W];
    end

    // Priority search over the mask rotated to start just above P.
    always_comb begin
        nxt   = p_q;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = p_q + SW'(k);
            if (!found && CH_MASK[idx]) begin
                found = 1'b1;
                nxt   = idx;
            end
        end
    end

    assign nxt_wraps = (nxt <= p_q);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= MANUAL;
            y_q     <= '0;
            ch_q    <= '0;
            vld_q   <= 1'b0;
            wrap_q  <= 1'b0;
            pend_q  <= 1'b0;
            p_q     <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            ch_q    <= ch_d;
            vld_q   <= vld_d;
            wrap_q  <= wrap_d;
            pend_q  <= pend_d;
            p_q     <= p_d;
            d_q     <= d_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (EN) begin
            state_d = MODE ? SCAN : MANUAL;
        end
    end

    always_comb begin
        y_d    = y_q;
        ch_d   = ch_q;
        vld_d  = 1'b0;
        wrap_d = 1'b0;
        pend_d = pend_q;
        p_d    = p_q;
        d_d    = d_q;
        if (EN) begin
            if (!MODE) begin
                y_d    = ch_data[S];
                ch_d   = S;
                vld_d  = 1'b1;
                pend_d = 1'b0;
                p_d    = S;
                d_d    = '0;
            end else if (state_q == MANUAL) begin
                p_d    = CH_MASK[p_q] ? p_q : nxt;
                pend_d = 1'b0;
                d_d    = '0;
            end else if (CH_MASK == '0) begin
                d_d = '0;
            end else if (!CH_MASK[p_q]) begin
                p_d    = nxt;
                pend_d = pend_q | nxt_wraps;
                d_d    = '0;
            end else begin
                // WRAP is deferred so it lines up with the wrapped channel's first sample.
                y_d    = ch_data[p_q];
                ch_d   = p_q;
                vld_d  = 1'b1;
                wrap_d = pend_q;
                pend_d = 1'b0;
                if (d_q == DLAST) begin
                    d_d    = '0;
                    p_d    = nxt;
                    pend_d = nxt_wraps;
                end else begin
                    d_d = d_q + 8'd1;
                end
            end
        end
    end

    assign Y       = y_q;
    assign Y_CH    = ch_q;
    assign Y_VALID = vld_q;
    assign WRAP    = wrap_q;

endmodule

// File: tb/tb_mux_scan_reg.sv
// Scoreboard bench for mux_scan_reg: one DWELL=1 and one DWELL=3 instance.
// Directed steps push expected outputs; per-instance monitors pop and compare.
module tb_mux_scan_reg;

    typedef struct packed {
        logic       v;
        logic       w;
        logic [3:0] ch;
        logic [7:0] y;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] din;
    logic [127:0] i_nxt;
    logic [3:0]   s;
    logic         mode;
    logic         en;
    logic [15:0]  mask;

    logic [7:0] y1, y3;
    logic [3:0] ch1, ch3;
    logic       v1, v3, w1, w3;

    exp_t q1[$];
    exp_t q3[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mux_scan_reg #(.SW(4), .W(8), .DWELL(1)) u_d1 (
        .CLK(clk), .RST_N(rst_n), .I(din), .S(s), .MODE(mode),
        .EN(en), .CH_MASK(mask), .Y(y1), .Y_CH(ch1),
        .Y_VALID(v1), .WRAP(w1)
    );

    mux_scan_reg #(.SW(4), .W(8), .DWELL(3)) u_d3 (
        .CLK(clk), .RST_N(rst_n), .I(din), .S(s), .MODE(mode),
        .EN(en), .CH_MASK(mask), .Y(y3), .Y_CH(ch3),
        .Y_VALID(v3), .WRAP(w3)
    );

    function automatic logic [7:0] yv(input logic [3:0] c);
        return 8'h10 + {4'h0, c};
    endfunction

    task automatic chk(input string nm, input exp_t act, input exp_t exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s #%0d: got v=%0b w=%0b ch=%0d y=%h, want v=%0b w=%0b ch=%0d y=%h",
                     nm, n_vec, act.v, act.w, act.ch, act.y,
                     exp.v, exp.w, exp.ch, exp.y);
        end
    endtask

    task automatic step(input int dut, input logic e, input logic m,
                        input logic [3:0] sel, input logic [15:0] mk,
                        input logic v, input logic w,
                        input logic [3:0] c, input logic [7:0] yy);
        exp_t x;
        @(negedge clk);
        en   = e;
        mode = m;
        s    = sel;
        mask = mk;
        din  = i_nxt;
        x.v  = v;
        x.w  = w;
        x.ch = c;
        x.y  = yy;
        if (dut == 1) q1.push_back(x);
        else          q3.push_back(x);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (q1.size() > 0) chk("dwell1", {v1, w1, ch1, y1}, q1.pop_front());
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (q3.size() > 0) chk("dwell3", {v3, w3, ch3, y3}, q3.pop_front());
    end

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        chk("rst_async_d1", {v1, w1, ch1, y1}, '0);
        chk("rst_async_d3", {v3, w3, ch3, y3}, '0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] c;
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 1'b0;
        s     = '0;
        mask  = '0;
        for (int k = 0; k < 16; k++) i_nxt[k*8 +: 8] = 8'h10 + 8'(k);
        din = i_nxt;
        #2;
        chk("rst_d1", {v1, w1, ch1, y1}, '0);
        chk("rst_d3", {v3, w3, ch3, y3}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // manual select, then full-mask scan from 9 with wrap onto 0
        step(1, 1, 0, 4'd9, 16'hFFFF, 1, 0, 4'd9, 8'h19);
        step(1, 1, 1, 4'd9, 16'hFFFF, 0, 0, 4'd9, 8'h19);
        for (int k = 0; k < 10; k++) begin
            c = 4'(9 + k);
            step(1, 1, 1, 4'd0, 16'hFFFF, 1, (c == 4'd0), c, yv(c));
        end

        // sparse mask, dwell 3, live resampling of I
        async_reset();
        step(3, 1, 0, 4'd0, 16'h8011, 1, 0, 4'd0, 8'h10);
        step(3, 1, 1, 4'd0, 16'h8011, 0, 0, 4'd0, 8'h10);
        for (int k = 0; k < 3; k++)
            step(3, 1, 1, 4'd0, 16'h8011, 1, 0, 4'd0, 8'h10);
        step(3, 1, 1, 4'd0, 16'h8011, 1, 0, 4'd4, 8'h14);
        i_nxt[4*8 +: 8] = 8'hAA;
        step(3, 1, 1, 4'd0, 16'h8011, 1, 0, 4'd4, 8'hAA);
        i_nxt[4*8 +: 8] = 8'h14;
        step(3, 1, 1, 4'd0, 16'h8011, 1, 0, 4'd4, 8'h14);
        for (int k = 0; k < 3; k++)
            step(3, 1, 1, 4'd0, 16'h8011, 1, 0, 4'd15, 8'h1F);
        step(3, 1, 1, 4'd0, 16'h8011, 1, 1, 4'd0, 8'h10);

        // EN gap mid-dwell: frozen, then the remaining 2 dwell cycles
        for (int k = 0; k < 5; k++)
            step(3, 0, 1, 4'd0, 16'h8011, 0, 0, 4'd0, 8'h10);
        step(3, 1, 1, 4'd0, 16'h8011, 1, 0, 4'd0, 8'h10);
        step(3, 1, 1, 4'd0, 16'h8011, 1, 0, 4'd0, 8'h10);
        step(3, 1, 1, 4'd0, 16'h8011, 1, 0, 4'd4, 8'h14);

        // current channel dropped from mask mid-dwell
        step(3, 1, 1, 4'd0, 16'h8001, 0, 0, 4'd4, 8'h14);
        for (int k = 0; k < 3; k++)
            step(3, 1, 1, 4'd0, 16'h8001, 1, 0, 4'd15, 8'h1F);
        step(3, 1, 1, 4'd0, 16'h8001, 1, 1, 4'd0, 8'h10);

        // empty mask holds, then single channel 2
        step(3, 1, 1, 4'd0, 16'h0000, 0, 0, 4'd0, 8'h10);
        step(3, 1, 1, 4'd0, 16'h0000, 0, 0, 4'd0, 8'h10);
        step(3, 1, 1, 4'd0, 16'h0004, 0, 0, 4'd0, 8'h10);
        for (int k = 0; k < 7; k++)
            step(3, 1, 1, 4'd0, 16'h0004, 1, (k == 3 || k == 6), 4'd2, 8'h12);

        // reset mid-scan restarts scan at channel 0
        async_reset();
        step(1, 1, 1, 4'd0, 16'hFFFF, 0, 0, 4'd0, 8'h00);
        for (int k = 0; k < 4; k++)
            step(1, 1, 1, 4'd0, 16'hFFFF, 1, 0, 4'(k), yv(4'(k)));

        repeat (3) @(posedge clk);
        #2;
        n_vec++;
        if (q1.size() + q3.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", q1.size() + q3.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
